ex_multdiv_iter: RTL and testbench
==================================

EX_MULTDIV_ITER -- requirements
Module: ex_multdiv_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even and at least 8.
REQ-002 The block SHALL have parameter OP_W, default 3, giving the opcode width; the value is fixed at 3.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i=1 and ready_o=1 at a rising edge.
- op_i  in  3  opcode, RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  in  WIDTH  operand A (rs1).
- op_b_i  in  WIDTH  operand B (rs2).
- kill_i  in  1  abort in-flight operation (EX flush).
- valid_o  out  1  result valid.
- ready_i  in  1  consumer (EX/WB) ready.
- result_o  out  WIDTH  result.
- busy_o  out  1  high when state is not IDLE.

Function
REQ-004 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-005 On the accepting edge the block SHALL capture op, |A|, |B| and the result sign, and move to CALC.
- Operand sign follows op: A signed for MULH, MULHSU, DIV, REM; B signed for MULH, DIV, REM; MUL treats both as unsigned.
- Changes to op_a_i, op_b_i or op_i after acceptance SHALL be ignored.
REQ-006 CALC SHALL run exactly WIDTH cycles, one iteration per cycle, counted by a $clog2(WIDTH)+1-bit counter, with no early termination (data-independent timing).
- Multiply: shift-add into a 2*WIDTH-bit magnitude product.
- Divide: restoring division producing a WIDTH-bit magnitude quotient and remainder.
REQ-007 FIX SHALL last one cycle and produce the result:
- Multiply: negate the 2*WIDTH-bit product if the operand signs differ; MUL returns the low WIDTH bits, MULH/MULHSU/MULHU the high WIDTH bits.
- Divide: negate the quotient if the operand signs differ; the remainder takes the sign of A.
REQ-008 Divide by zero (B==0) SHALL override FIX: DIV/DIVU return all ones; REM/REMU return A unmodified. Latency is unchanged.
REQ-009 Signed overflow (A = -2^(WIDTH-1), B = -1) SHALL return quotient -2^(WIDTH-1) and remainder 0.
REQ-010 Latency: valid_o SHALL first be 1 in the cycle after the (WIDTH+1)th rising edge following the accepting edge (WIDTH=32: 33 edges).
REQ-011 In DONE, valid_o=1 and result_o SHALL hold stable until valid_o and ready_i are both 1 at an edge.
REQ-012 ready_o SHALL be 1 in IDLE, and in DONE when ready_i=1; it SHALL be 0 otherwise.
- A DONE handshake with simultaneous acceptance SHALL go directly DONE->CALC (back-to-back, no bubble).
- A DONE handshake without acceptance SHALL go to IDLE.
REQ-013 kill_i=1 at an edge SHALL force IDLE from any state and discard the in-flight operation.
- kill_i has priority over valid_i, and no request is accepted on that edge.
- valid_o SHALL be 0 in the cycle after the kill.
REQ-014 busy_o SHALL be 1 whenever the state is CALC, FIX or DONE.
REQ-015 result_o SHALL retain its last value outside DONE; consumers qualify it only with valid_o.

Reset
REQ-016 Asserting rst_ni=0 SHALL immediately, without a clock edge, set state=IDLE, valid_o=0, result_o=0, counter=0, busy_o=0 and ready_o=1.
REQ-017 Reset asserted mid-operation SHALL abort that operation; after release, the first accepted request SHALL complete with correct result and latency.

Verification (WIDTH=32)
REQ-018 MUL 7 x 0xFFFFFFFD -> result_o 0xFFFFFFEB; valid_o rises exactly 33 edges after acceptance; busy_o high throughout.
REQ-019 Multiply-high cases:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-020 Divide cases:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; each with the 33-edge latency.
REQ-021 kill_i pulsed 10 cycles into CALC -> busy_o=0 next cycle and no valid_o. Then a DIVU 100/7 request -> 14 at normal latency.
REQ-022 ready_i held 0 for 5 cycles in DONE -> valid_o and result_o stable. Then ready_i=1 with valid_i=1 (MUL 3x4) -> accepted on the same edge, result 12 after 33 edges.
REQ-023 rst_ni pulsed low mid-CALC -> valid_o=0 and busy_o=0 asynchronously. After release, MULHU 0x10000 x 0x10000 -> 1.

Source files
------------

// File: rtl/ex_multdiv_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide.
// Fixed WIDTH-cycle CALC phase, one-cycle sign fix-up, DONE holds until the consumer takes it.
module ex_multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [OP_W-1:0]  op_q;
  logic             neg_a_q, neg_b_q, b_zero_q;
  logic [WIDTH-1:0] a_q, addend_q, hi_q, lo_q;

  logic             sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, fix_res;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Operand sign decode and magnitudes at the request boundary
  always_comb begin
    sgn_a    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sgn_b    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    in_neg_a = sgn_a & op_a_i[WIDTH-1];
    in_neg_b = sgn_b & op_b_i[WIDTH-1];
    mag_a    = cond_neg(op_a_i, in_neg_a);
    mag_b    = cond_neg(op_b_i, in_neg_b);
  end

  // One iteration step: hi_q:lo_q is the product, or remainder:dividend/quotient
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, addend_q};
    prod_s    = cond_neg2({hi_q, lo_q}, neg_a_q ^ neg_b_q);
  end

  always_comb begin
    if (!op_q[2])
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    else if (b_zero_q)
      fix_res = op_q[1] ? a_q : '1;
    else if (op_q[1])
      fix_res = cond_neg(hi_q, neg_a_q);
    else
      fix_res = cond_neg(lo_q, neg_a_q ^ neg_b_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (valid_i) state_nxt = CALC;
        CALC:    if (cnt == LAST) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (ready_i) state_nxt = valid_i ? CALC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = (state == IDLE) || ((state == DONE) && ready_i);
    valid_o = (state == DONE);
    busy_o  = (state != IDLE);
    accept  = valid_i && ready_o && !kill_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      result_o <= '0;
    end else begin
      if (accept)              cnt <= '0;
      else if (state == CALC)  cnt <= cnt + CNT_W'(1);
      if (state == FIX && !kill_i) result_o <= fix_res;
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q     <= op_i;
      a_q      <= op_a_i;
      neg_a_q  <= in_neg_a;
      neg_b_q  <= in_neg_b;
      b_zero_q <= (op_b_i == '0);
      addend_q <= op_i[2] ? mag_b : mag_a;
      lo_q     <= op_i[2] ? mag_a : mag_b;
      hi_q     <= '0;
    end else if (state == CALC) begin
      if (!op_q[2]) begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
        hi_q <= div_diff[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_q <= div_trial[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_ex_multdiv_iter.sv
// Bench for ex_multdiv_iter (WIDTH=32): directed vector table, random ops against
// a plain-arithmetic model, and hand sequences for kill, stall and mid-op reset.
module tb_ex_multdiv_iter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, valid, ready, kill, vld_out, cons_rdy, busy;
  logic [2:0]    op;
  logic [W-1:0]  a, b, res;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t tbl[$];

  ex_multdiv_iter #(.WIDTH(W), .OP_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .op_i(op), .op_a_i(a), .op_b_i(b), .kill_i(kill),
    .valid_o(vld_out), .ready_i(cons_rdy), .result_o(res), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference computed straight from the RISC-V M-extension definitions
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, uy;
    longint unsigned ux, uyu;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uyu = 64'(y);
    uy = longint'(uyu);
    case (o)
      3'd0: begin p = ux * uyu; return p[31:0]; end
      3'd1: begin p = sx * sy;  return p[63:32]; end
      3'd2: begin p = sx * uy;  return p[63:32]; end
      3'd3: begin p = ux * uyu; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  // Called at a negedge with a request driven and ready_o high; returns at the
  // negedge where valid_o is first seen (or after the cycle budget runs out).
  task automatic wait_result(input string name, input logic [31:0] exp);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
    chk({name, "_vld_early"}, 32'(vld_out), 32'd0);
    while (!vld_out && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, "_lat"}, 32'(n), 32'd33);
    chk({name, "_busy"}, 32'(busy_ok && busy), 32'd1);
    chk({name, "_res"}, res, exp);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    @(negedge clk);
    chk({name, "_rdy"}, 32'(ready), 32'd1);
    drive(o, x, y);
    wait_result(name, exp);
  endtask

  initial begin
    bit seen;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    tbl.push_back('{"mul_7xm3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    tbl.push_back('{"mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    tbl.push_back('{"mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    tbl.push_back('{"mulhsu_max",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
    tbl.push_back('{"div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    tbl.push_back('{"rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    tbl.push_back('{"div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    tbl.push_back('{"rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{"divu_5_0",     3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
    tbl.push_back('{"remu_5_0",     3'd7, 32'd5,          32'd0,         32'd5});
    tbl.push_back('{"div_m5_0",     3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF});
    tbl.push_back('{"rem_m5_0",     3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB});
    tbl.push_back('{"remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2});
    tbl.push_back('{"mul_min_m1",   3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    tbl.push_back('{"mulh_min_m1",  3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0});

    rst_n = 1'b0;
    valid = 1'b0;
    kill = 1'b0;
    cons_rdy = 1'b1;
    op = '0;
    a = '0;
    b = '0;
    #1;
    chk("rst_valid", 32'(vld_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_result", res, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op("rand", ro, ra, rb, ref_model(ro, ra, rb));
    end

    // Kill ten cycles into CALC
    @(negedge clk);
    drive(3'd5, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_valid", 32'(vld_out), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vld_out) seen = 1'b1;
    end
    chk("kill_no_valid", 32'(seen), 32'd0);
    // Kill wins over a simultaneous request
    @(negedge clk);
    drive(3'd0, 32'd2, 32'd2);
    kill = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    kill = 1'b0;
    chk("kill_prio_busy", 32'(busy), 32'd0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);

    // Consumer stall in DONE, then back-to-back accept on the handshake edge
    @(negedge clk);
    cons_rdy = 1'b0;
    drive(3'd0, 32'd5, 32'd6);
    wait_result("stall_first", 32'd30);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(vld_out), 32'd1);
      chk("stall_result", res, 32'd30);
    end
    cons_rdy = 1'b1;
    drive(3'd0, 32'd3, 32'd4);
    #1;
    chk("b2b_ready", 32'(ready), 32'd1);
    wait_result("b2b_mul", 32'd12);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(vld_out), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(ready), 32'd1);
    chk("mrst_result", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mulhu_after_rst", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
